// File: rtl/stat_link.sv
// Serial status link between two boards: frames the local 3-bit status onto link_tx
// and recovers the opponent's status. Define STAT_LINK_LOOPBACK_EN to feed RX from link_tx.
module stat_link #(
  parameter int BIT_TICKS      = 16,
  parameter int TIMEOUT_FRAMES = 8
) (
  input  logic       global_clk,
  input  logic       rst,
  input  logic [2:0] stat_local,
  input  logic       link_rx,
  output logic       link_tx,
  output logic [2:0] stat_sync,
  output logic       sync_valid,
  output logic       frame_err,
  output logic       link_up
);

  localparam int TW = $clog2(BIT_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(BIT_TICKS / 2 - 1);
  localparam int TO_LIMIT = TIMEOUT_FRAMES * 8 * BIT_TICKS;
  localparam int TOW = $clog2(TO_LIMIT);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TO_LIMIT - 1);

  typedef enum logic [2:0] {TX_GAP, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [TW-1:0]   tx_tick_q, tx_tick_d;
  logic [1:0]      tx_bit_q, tx_bit_d;
  logic [2:0]      tx_sh_q, tx_sh_d;
  logic            tx_par_q, tx_par_d;
  logic            link_tx_q, link_tx_d;

  rx_state_e       rx_state_q, rx_state_d;
  logic [TW-1:0]   rx_tick_q, rx_tick_d;
  logic [1:0]      rx_bit_q, rx_bit_d;
  logic [2:0]      rx_data_q, rx_data_d;
  logic            rx_par_q, rx_par_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic            rx_src;
  logic            frame_ok;

  logic [2:0]      stat_sync_q, stat_sync_d;
  logic            sync_valid_q, sync_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            link_up_q, link_up_d;
  logic [TOW-1:0]  to_q, to_d;

`ifdef STAT_LINK_LOOPBACK_EN
  logic unused_link_rx;
  assign unused_link_rx = link_rx;
  assign rx_src = link_tx_q;
`else
  assign rx_src = link_rx;
`endif

  // Transmitter: gap(2 bits), start, d0..d2, parity, stop; the next line value is
  // registered one bit boundary ahead so link_tx comes straight from a flop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    link_tx_d  = link_tx_q;
    if (tx_tick_q == TICK_LAST) begin
      tx_tick_d = '0;
      unique case (tx_state_q)
        TX_GAP: begin
          if (tx_bit_q == 2'd1) begin
            tx_state_d = TX_START;
            tx_bit_d   = 2'd0;
            tx_sh_d    = stat_local;
            tx_par_d   = ^stat_local;
            link_tx_d  = 1'b0;
          end else begin
            tx_bit_d = tx_bit_q + 2'd1;
          end
        end
        TX_START: begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 2'd0;
          link_tx_d  = tx_sh_q[0];
          tx_sh_d    = tx_sh_q >> 1;
        end
        TX_DATA: begin
          if (tx_bit_q == 2'd2) begin
            tx_state_d = TX_PAR;
            link_tx_d  = tx_par_q;
          end else begin
            tx_bit_d  = tx_bit_q + 2'd1;
            link_tx_d = tx_sh_q[0];
            tx_sh_d   = tx_sh_q >> 1;
          end
        end
        TX_PAR: begin
          tx_state_d = TX_STOP;
          link_tx_d  = 1'b1;
        end
        default: begin
          tx_state_d = TX_GAP;
          tx_bit_d   = 2'd0;
          link_tx_d  = 1'b1;
        end
      endcase
    end
  end

  // Receiver: start bit checked at half a bit, then every bit sampled at its centre.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_tick_d    = rx_tick_q + 1'b1;
    rx_bit_d     = rx_bit_q;
    rx_data_d    = rx_data_q;
    rx_par_d     = rx_par_q;
    frame_ok     = 1'b0;
    frame_err_d  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_tick_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_tick_q == TICK_HALF) begin
          rx_tick_d  = '0;
          rx_bit_d   = 2'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick_q == TICK_LAST) begin
          rx_tick_d = '0;
          rx_data_d = {rx_sync_q, rx_data_q[2:1]};
          if (rx_bit_q == 2'd2) rx_state_d = RX_PAR;
          else                  rx_bit_d   = rx_bit_q + 2'd1;
        end
      end
      RX_PAR: begin
        if (rx_tick_q == TICK_LAST) begin
          rx_tick_d  = '0;
          rx_par_d   = rx_sync_q;
          rx_state_d = RX_STOP;
        end
      end
      default: begin
        if (rx_tick_q == TICK_LAST) begin
          rx_tick_d  = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q && (rx_par_q == ^rx_data_q)) frame_ok    = 1'b1;
          else                                       frame_err_d = 1'b1;
        end
      end
    endcase
  end

  // Link supervision: a good frame always beats a simultaneous timeout.
  always_comb begin
    stat_sync_d  = stat_sync_q;
    sync_valid_d = 1'b0;
    link_up_d    = link_up_q;
    to_d         = '0;
    if (frame_ok) begin
      stat_sync_d  = rx_data_q;
      sync_valid_d = 1'b1;
      link_up_d    = 1'b1;
    end else if (link_up_q) begin
      if (to_q == TO_LAST) begin
        link_up_d   = 1'b0;
        stat_sync_d = 3'b000;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge global_clk) begin
    if (rst) begin
      tx_state_q   <= TX_GAP;
      tx_tick_q    <= '0;
      tx_bit_q     <= 2'd0;
      tx_sh_q      <= 3'b000;
      tx_par_q     <= 1'b0;
      link_tx_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_tick_q    <= '0;
      rx_bit_q     <= 2'd0;
      rx_data_q    <= 3'b000;
      rx_par_q     <= 1'b0;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      stat_sync_q  <= 3'b000;
      sync_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      link_up_q    <= 1'b0;
      to_q         <= '0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_tick_q    <= tx_tick_d;
      tx_bit_q     <= tx_bit_d;
      tx_sh_q      <= tx_sh_d;
      tx_par_q     <= tx_par_d;
      link_tx_q    <= link_tx_d;
      rx_state_q   <= rx_state_d;
      rx_tick_q    <= rx_tick_d;
      rx_bit_q     <= rx_bit_d;
      rx_data_q    <= rx_data_d;
      rx_par_q     <= rx_par_d;
      rx_meta_q    <= rx_src;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      stat_sync_q  <= stat_sync_d;
      sync_valid_q <= sync_valid_d;
      frame_err_q  <= frame_err_d;
      link_up_q    <= link_up_d;
      to_q         <= to_d;
    end
  end

  assign link_tx    = link_tx_q;
  assign stat_sync  = stat_sync_q;
  assign sync_valid = sync_valid_q;
  assign frame_err  = frame_err_q;
  assign link_up    = link_up_q;

endmodule

// File: tb/tb_stat_link.sv
// Bench for stat_link: wired self-loop scoreboard, timeout, glitch and randomized
// bench-driven frames checked against a frame-level model.
module tb_stat_link;
  localparam int BT = 16;

  logic       global_clk = 1'b0;
  logic       rst;
  logic [2:0] stat_local;
  logic       link_rx;
  logic       link_tx;
  logic [2:0] stat_sync;
  logic       sync_valid;
  logic       frame_err;
  logic       link_up;

  logic wired;
  logic rx_drv;
  assign link_rx = wired ? link_tx : rx_drv;

  stat_link #(.BIT_TICKS(BT), .TIMEOUT_FRAMES(8)) dut (
    .global_clk(global_clk), .rst(rst), .stat_local(stat_local), .link_rx(link_rx),
    .link_tx(link_tx), .stat_sync(stat_sync), .sync_valid(sync_valid),
    .frame_err(frame_err), .link_up(link_up)
  );

  always #5 global_clk = ~global_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sv_cnt = 0;
  int fe_cnt = 0;
  int last_sv = -100000;
  int prev_sv = -100000;
  int wired_pulses = 0;
  logic [2:0] exp_q[$];

  // frame-level model state for bench-driven frames
  bit         have_valid = 0;
  int         mdl_last = 0;
  logic [2:0] mdl_data = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge global_clk);
    #1;
    cyc++;
    // every frame start (32 + 128k after release) carries the status present at that edge
    if (wired && !rst && cyc >= 2*BT && ((cyc - 2*BT) % (8*BT)) == 0)
      exp_q.push_back(stat_local);
    if (sync_valid === 1'b1) begin
      sv_cnt++;
      prev_sv = last_sv;
      last_sv = cyc;
      if (wired) begin
        wired_pulses++;
        chk("sb_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) chk("sb_stat_sync", stat_sync, exp_q.pop_front());
        if (wired_pulses == 1)
          chk("first_pulse_in_stop_bit", (cyc >= 2*BT + 5*BT) && (cyc < 2*BT + 6*BT), 1);
        else
          chk("sb_period", last_sv - prev_sv, 8*BT);
      end
    end
    if (frame_err === 1'b1) fe_cnt++;
  endtask

  task automatic run_frame(input logic [2:0] d, input int kind, input string tag);
    int sv0, fe0, c0;
    logic p, ok, exp_up;
    logic [2:0] exp_ss;
    sv0 = sv_cnt; fe0 = fe_cnt; c0 = cyc;
    ok = (kind == 0);
    p  = (^d) ^ (kind == 1);
    rx_drv = 1'b0; repeat (BT) step();
    for (int i = 0; i < 3; i++) begin
      rx_drv = d[i]; repeat (BT) step();
    end
    rx_drv = p; repeat (BT) step();
    rx_drv = (kind != 2); repeat (BT) step();
    rx_drv = 1'b1; repeat (2*BT) step();
    if (ok) begin
      have_valid = 1;
      mdl_last   = c0 + 5*BT + BT/2 + 3;
      mdl_data   = d;
    end
    exp_up = have_valid && ((cyc - mdl_last) < 8*8*BT);
    exp_ss = exp_up ? mdl_data : 3'b000;
    chk({tag, "_sync_valid_cnt"}, sv_cnt - sv0, {31'd0, ok});
    chk({tag, "_frame_err_cnt"}, fe_cnt - fe0, {31'd0, !ok});
    chk({tag, "_link_up"}, link_up, exp_up);
    chk({tag, "_stat_sync"}, stat_sync, exp_ss);
  endtask

  initial begin
    int t0, sv0, fe0;
    rst = 1'b1; stat_local = 3'b001; wired = 1'b1; rx_drv = 1'b1;
    repeat (3) step();
    chk("rst_link_tx", link_tx, 1);
    chk("rst_stat_sync", stat_sync, 0);
    chk("rst_link_up", link_up, 0);
    chk("rst_sync_valid", sync_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0; cyc = 0; sv_cnt = 0; fe_cnt = 0;

    repeat (2*BT - 1) step();
    chk("tx_gap_before_start", link_tx, 1);
    step();
    chk("tx_start_at_32", link_tx, 0);

    // change status in the middle of the frame that starts at 416
    while (cyc < 464) step();
    stat_local = 3'b011;
    while (cyc < 520) step();
    chk("frame_carries_old", stat_sync, 3'b001);
    chk("link_up_wired", link_up, 1);
    while (cyc < 772) step();
    chk("frame_carries_new", stat_sync, 3'b011);
    chk("wired_pulse_count", wired_pulses, 6);
    chk("fe_wired", fe_cnt, 0);

    // silence the line and time the link-down
    wired = 1'b0; rx_drv = 1'b1; exp_q.delete();
    t0 = last_sv;
    while (link_up === 1'b1 && cyc < t0 + 2000) step();
    chk("timeout_latency", cyc - t0, 1024);
    chk("timeout_stat_sync", stat_sync, 0);

    sv0 = sv_cnt; fe0 = fe_cnt;
    rx_drv = 1'b0; repeat (4) step();
    rx_drv = 1'b1; repeat (40) step();
    chk("glitch_sync_valid", sv_cnt - sv0, 0);
    chk("glitch_frame_err", fe_cnt - fe0, 0);

    run_frame(3'b101, 0, "good_101");
    run_frame(3'b101, 1, "bad_parity_101");
    for (int n = 0; n < 14; n++) begin
      int r;
      r = $urandom_range(0, 3);
      run_frame(3'($urandom_range(0, 7)), (r < 2) ? r + 1 : 0, "rand");
    end

    // reset in the middle of a frame
    rx_drv = 1'b0; repeat (20) step();
    rst = 1'b1; repeat (2) step();
    chk("midrst_link_up", link_up, 0);
    chk("midrst_stat_sync", stat_sync, 0);
    chk("midrst_link_tx", link_tx, 1);
    chk("midrst_frame_err", frame_err, 0);
    rst = 1'b0; rx_drv = 1'b1;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
